// File: rtl/ser_pkg.sv
// Shared definitions for the serial front-end: FSM state encoding and sizing helpers.
package ser_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } ser_state_e;

  // Number of bits needed to count 0..value-1; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and emits it one bit
// per clock on ser_out, with back-to-back frames and a fixed idle level between frames.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  // Counter only has to reach WIDTH-1; keep at least one bit for degenerate sizes.
  localparam int unsigned     CntW    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             last_bit;
  logic             acc;
  logic             head_bit;
  logic [WIDTH-1:0] shreg_shifted;

  assign last_bit = (state_q == StShift) && (cnt_q == CntLast);

  // Ready in IDLE, or during the final bit so the next word lands with no bubble.
  assign data_ready = !rst && ((state_q == StIdle) || last_bit);
  assign acc        = data_valid && data_ready;

  // Head bit is the one presented this cycle; shifting moves the next bit into its place.
  assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  // Next-state logic for FSM, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (last_bit) begin
          if (acc) begin
            shreg_d = data_in;
            cnt_d   = '0;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end else begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only, so they are glitch-free.
  always_comb begin
    ser_valid  = (state_q == StShift);
    busy       = ser_valid;
    ser_out    = ser_valid ? head_bit : IDLE_BIT;
    frame_done = last_bit;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based reference model plus directed literals.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       frame_done;

  logic       b_rst;
  logic [3:0] b_data_in;
  logic       b_valid;
  logic       b_ready;
  logic       b_ser_out;
  logic       b_ser_valid;
  logic       b_busy;
  logic       b_frame_done;

  int n_total  = 0;
  int n_passed = 0;

  piso_serializer #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1),
    .IDLE_BIT  (1'b0)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  piso_serializer #(
    .WIDTH     (4),
    .MSB_FIRST (1'b0),
    .IDLE_BIT  (1'b1)
  ) u_dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .data_in    (b_data_in),
    .data_valid (b_valid),
    .data_ready (b_ready),
    .ser_out    (b_ser_out),
    .ser_valid  (b_ser_valid),
    .busy       (b_busy),
    .frame_done (b_frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_passed++;
  endtask

  // Reference model: a queue of bits still to be shown. Head of queue is on ser_out now.
  bit q[$];
  bit model_en = 1'b0;
  bit m_acc;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        model_en = 1'b1;
      end else if (model_en) begin
        m_acc = data_valid && (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (m_acc) for (int i = 0; i < 8; i++) q.push_back(data_in[7-i]);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en) begin
        check("m_ser_valid", 32'(ser_valid), 32'(q.size() > 0));
        check("m_busy", 32'(busy), 32'(q.size() > 0));
        check("m_ser_out", 32'(ser_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("m_frame_done", 32'(frame_done), 32'(q.size() == 1));
        check("m_data_ready", 32'(data_ready), 32'(!rst && (q.size() <= 1)));
      end
    end
  end

  task automatic single(input logic [7:0] w, output logic [7:0] bits, output int vcnt,
                        output int fdcnt, output int fdpos);
    @(posedge clk); #1;
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    bits  = '0;
    vcnt  = 0;
    fdcnt = 0;
    fdpos = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) bits[7-i] = ser_out;
      if (ser_valid) vcnt++;
      if (frame_done) begin
        fdcnt++;
        fdpos = i;
      end
    end
  endtask

  // Two words; second is offered with valid from frame cycle hold_from through the last bit.
  task automatic two_words(input logic [7:0] w0, input logic [7:0] w1, input int hold_from,
                           output logic [15:0] seq, output logic [15:0] rdy, output int vcnt);
    @(posedge clk); #1;
    data_in    = w0;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_in    = w1;
    data_valid = (hold_from <= 1);
    seq  = '0;
    rdy  = '0;
    vcnt = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 16) begin
        seq[15-i] = ser_out;
        rdy[i]    = data_ready;
      end
      if (ser_valid) vcnt++;
      @(posedge clk); #1;
      data_valid = (i + 2 >= hold_from) && (i + 2 <= 8);
    end
  endtask

  logic [7:0]  bits;
  logic [15:0] seq;
  logic [15:0] rdy;
  logic [4:0]  bseq;
  logic [4:0]  bval;
  int          vcnt, fdcnt, fdpos;

  initial begin
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'h55;
    b_rst      = 1'b1;
    b_valid    = 1'b0;
    b_data_in  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_b_ser_out_idle", 32'(b_ser_out), 32'd1);
    // rst and data_valid both high at this edge: the word must not be taken.
    @(posedge clk); #1;
    rst        = 1'b0;
    b_rst      = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    check("rst_valid_no_frame", 32'(ser_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_persists", 32'(ser_valid), 32'd0);

    single(8'hB0, bits, vcnt, fdcnt, fdpos);
    check("b0_bits", 32'(bits), 32'hB0);
    check("b0_valid_cycles", 32'(vcnt), 32'd8);
    check("b0_frame_done_count", 32'(fdcnt), 32'd1);
    check("b0_frame_done_pos", 32'(fdpos), 32'd7);

    two_words(8'hB0, 8'h0B, 1, seq, rdy, vcnt);
    check("b2b_bits", 32'(seq), 32'hB00B);
    check("b2b_ready_mask", 32'(rdy), 32'h8080);
    check("b2b_valid_cycles", 32'(vcnt), 32'd16);

    two_words(8'hA5, 8'h3C, 2, seq, rdy, vcnt);
    check("hold_bits", 32'(seq), 32'hA53C);
    check("hold_valid_cycles", 32'(vcnt), 32'd16);

    // Reset in cycle 3 of a frame.
    @(posedge clk); #1;
    data_in    = 8'hC3;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ser_valid", 32'(ser_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ser_out", 32'(ser_out), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    single(8'h81, bits, vcnt, fdcnt, fdpos);
    check("after_rst_bits", 32'(bits), 32'h81);
    check("after_rst_valid_cycles", 32'(vcnt), 32'd8);

    // Narrow LSB-first instance with idle level 1.
    @(posedge clk); #1;
    b_data_in = 4'b1101;
    b_valid   = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bseq[i] = b_ser_out;
      bval[i] = b_ser_valid;
    end
    check("w4_bits", 32'(bseq), 32'b11101);
    check("w4_valid", 32'(bval), 32'b01111);

    // Randomized traffic with occasional resets, checked by the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 63) == 0);
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 8'($urandom);
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    data_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
